// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 key-schedule constants and the key-schedule sequencer state
// type. Imported by aes_rk_store and aes_key_sched_ctrl.
//   AES_KEY_W  : width of a cipher key / round key
//   AES_NUM_RND: number of key-expansion rounds
//   AES_NUM_RK : number of banked round keys (cipher key + one per round)
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_KEY_W   = 128;
  localparam int AES_NUM_RND = 10;
  localparam int AES_NUM_RK  = AES_NUM_RND + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ks_state_t;

  // A new cipher key may only be taken while no expansion is running.
  function automatic logic ks_accepts_key(input ks_state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/aes_rk_store.sv
// ----------------------------------------------------------------------------
// aes_rk_store
// Round-key register file: DEPTH entries of KEY_W bits.
//   clk, rst         : clock, synchronous active-high reset (read data only;
//                      the key array itself is never cleared)
//   we/waddr/wdata   : single write port
//   araddr -> ardata : asynchronous read port (previous key for aes_key_gen)
//   rd_en/rd_clr/rd_addr -> rd_data : registered read port (cipher core).
//                      rd_clr forces the registered data to zero, rd_en loads
//                      the addressed entry, neither holds the last value.
// ----------------------------------------------------------------------------
module aes_rk_store
  import aes_pkg::*;
#(
  parameter int KEY_W = AES_KEY_W,
  parameter int DEPTH = AES_NUM_RK,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic [AW-1:0]    araddr,
  output logic [KEY_W-1:0] ardata,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [AW-1:0]    rd_addr,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [KEY_W-1:0] rd_data_q;
  logic [KEY_W-1:0] rd_data_d;

  // Key storage carries no reset: validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign ardata = (int'(araddr) < DEPTH) ? mem_q[araddr] : '0;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_clr) begin
      rd_data_d = '0;
    end else if (rd_en && (int'(rd_addr) < DEPTH)) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// aes_key_sched_ctrl
// Sequences an external aes_key_gen through the AES-128 key expansion and
// banks the resulting round keys (index 0 = cipher key) for the cipher core.
//   clk, rst            : clock, synchronous active-high reset
//   i_key_vld, i_key    : cipher-key offer, taken when o_key_rdy=1
//   o_key_rdy           : controller idle or finished, can take a key
//   o_kg_en             : one-cycle start pulse to aes_key_gen
//   o_kg_round_num      : round index for aes_key_gen
//   o_kg_pre_key        : previous round key for aes_key_gen
//   i_kg_next_key       : next round key returned by aes_key_gen
//   i_rk_rd_en, i_rk_addr -> o_rk, o_rk_vld, o_rk_err : round-key read port,
//                         one-cycle latency
//   o_busy              : expansion in progress
//   o_keys_ready        : full round-key set valid
// Each round takes one ISSUE cycle plus KG_LAT WAIT cycles.
// ----------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_W   = AES_KEY_W,
  parameter int NUM_RND = AES_NUM_RND,
  parameter int KG_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_key_vld,
  input  logic [KEY_W-1:0] i_key,
  output logic             o_key_rdy,
  output logic             o_kg_en,
  output logic [3:0]       o_kg_round_num,
  output logic [KEY_W-1:0] o_kg_pre_key,
  input  logic [KEY_W-1:0] i_kg_next_key,
  input  logic             i_rk_rd_en,
  input  logic [3:0]       i_rk_addr,
  output logic [KEY_W-1:0] o_rk,
  output logic             o_rk_vld,
  output logic             o_rk_err,
  output logic             o_busy,
  output logic             o_keys_ready
);

  localparam int         NUM_RK   = NUM_RND + 1;
  localparam int         CNT_W    = 3;
  localparam logic [3:0] RND_LAST = 4'(NUM_RND - 1);
  localparam logic [3:0] ADDR_MAX = 4'(NUM_RND);

  // Sequencer state
  ks_state_t        state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             keys_ready_q, keys_ready_d;

  // Registered outputs
  logic             kg_en_q, kg_en_d;
  logic             key_rdy_q, key_rdy_d;
  logic             busy_q, busy_d;
  logic             rk_vld_q, rk_vld_d;
  logic             rk_err_q, rk_err_d;

  // Round-key store ports
  logic             rk_we;
  logic [3:0]       rk_waddr;
  logic [KEY_W-1:0] rk_wdata;
  logic [KEY_W-1:0] rk_pre_key;
  logic             rd_ok;
  logic             rd_bad;

  aes_rk_store #(
    .KEY_W (KEY_W),
    .DEPTH (NUM_RK),
    .AW    (4)
  ) u_rk_store (
    .clk     (clk),
    .rst     (rst),
    .we      (rk_we),
    .waddr   (rk_waddr),
    .wdata   (rk_wdata),
    .araddr  (rnd_q),
    .ardata  (rk_pre_key),
    .rd_en   (rd_ok),
    .rd_clr  (rd_bad),
    .rd_addr (i_rk_addr),
    .rd_data (o_rk)
  );

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    cnt_d        = cnt_q;
    keys_ready_d = keys_ready_q;
    rk_we        = 1'b0;
    rk_waddr     = '0;
    rk_wdata     = '0;

    case (state_q)
      IDLE, DONE: begin
        // A rekey from DONE invalidates the bank on the accept edge.
        if (i_key_vld && key_rdy_q) begin
          rk_we        = 1'b1;
          rk_waddr     = '0;
          rk_wdata     = i_key;
          rnd_d        = '0;
          cnt_d        = '0;
          keys_ready_d = 1'b0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = CNT_W'(KG_LAT);
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Count of 1 marks the cycle aes_key_gen's result is valid.
        if (cnt_q == CNT_W'(1)) begin
          rk_we    = 1'b1;
          rk_waddr = rnd_q + 4'd1;
          rk_wdata = i_kg_next_key;
          if (rnd_q == RND_LAST) begin
            keys_ready_d = 1'b1;
            state_d      = DONE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    kg_en_d   = (state_d == ISSUE);
    key_rdy_d = ks_accepts_key(state_d);
    busy_d    = !ks_accepts_key(state_d);
  end

  // Read port: judged against the pre-edge bank, so a read that coincides
  // with a rekey accept still returns the old key set.
  always_comb begin
    rd_ok    = i_rk_rd_en && keys_ready_q && (i_rk_addr <= ADDR_MAX);
    rd_bad   = i_rk_rd_en && !rd_ok;
    rk_vld_d = rd_ok;
    rk_err_d = rd_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      cnt_q        <= '0;
      keys_ready_q <= 1'b0;
      kg_en_q      <= 1'b0;
      key_rdy_q    <= 1'b1;
      busy_q       <= 1'b0;
      rk_vld_q     <= 1'b0;
      rk_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      cnt_q        <= cnt_d;
      keys_ready_q <= keys_ready_d;
      kg_en_q      <= kg_en_d;
      key_rdy_q    <= key_rdy_d;
      busy_q       <= busy_d;
      rk_vld_q     <= rk_vld_d;
      rk_err_q     <= rk_err_d;
    end
  end

  assign o_key_rdy      = key_rdy_q;
  assign o_kg_en        = kg_en_q;
  assign o_kg_round_num = rnd_q;
  // The previous key is only presented while an expansion is running;
  // it stays stable through WAIT because rk[rnd] is not rewritten there.
  assign o_kg_pre_key   = busy_q ? rk_pre_key : '0;
  assign o_rk_vld       = rk_vld_q;
  assign o_rk_err       = rk_err_q;
  assign o_busy         = busy_q;
  assign o_keys_ready   = keys_ready_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Two controller instances (KG_LAT=1 and KG_LAT=3), each paired with a
// behavioural aes_key_gen. Round-key reads push their expected response to a
// per-instance queue; the response is popped and compared one cycle later.
// ----------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] POISON    = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  localparam int           LIMIT     = 200;

  typedef struct packed {
    logic         vld;
    logic         err;
    logic [3:0]   addr;
    logic [127:0] data;
  } sb_ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_key_vld = 1'b0;
  logic [127:0] i_key = '0;

  logic rd_en_1 = 1'b0, rd_en_3 = 1'b0;
  logic [3:0] rd_addr_1 = '0, rd_addr_3 = '0;

  logic key_rdy_1, kg_en_1, rk_vld_1, rk_err_1, busy_1, ready_1;
  logic key_rdy_3, kg_en_3, rk_vld_3, rk_err_3, busy_3, ready_3;
  logic [3:0] kg_rnd_1, kg_rnd_3;
  logic [127:0] kg_pre_1, kg_next_1, rk_1;
  logic [127:0] kg_pre_3, kg_next_3, rk_3;
  logic [127:0] p0_3, p1_3, p2_3;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk [11];
  sb_ent_t      sb1 [$];
  sb_ent_t      sb3 [$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.KEY_W(128), .NUM_RND(10), .KG_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .i_key_vld(i_key_vld), .i_key(i_key),
    .o_key_rdy(key_rdy_1), .o_kg_en(kg_en_1), .o_kg_round_num(kg_rnd_1),
    .o_kg_pre_key(kg_pre_1), .i_kg_next_key(kg_next_1),
    .i_rk_rd_en(rd_en_1), .i_rk_addr(rd_addr_1), .o_rk(rk_1),
    .o_rk_vld(rk_vld_1), .o_rk_err(rk_err_1), .o_busy(busy_1),
    .o_keys_ready(ready_1)
  );

  aes_key_sched_ctrl #(.KEY_W(128), .NUM_RND(10), .KG_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .i_key_vld(i_key_vld), .i_key(i_key),
    .o_key_rdy(key_rdy_3), .o_kg_en(kg_en_3), .o_kg_round_num(kg_rnd_3),
    .o_kg_pre_key(kg_pre_3), .i_kg_next_key(kg_next_3),
    .i_rk_rd_en(rd_en_3), .i_rk_addr(rd_addr_3), .o_rk(rk_3),
    .o_rk_vld(rk_vld_3), .o_rk_err(rk_err_3), .o_busy(busy_3),
    .o_keys_ready(ready_3)
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [7:0] r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] kg_fn(input logic [127:0] pre, input logic [3:0] rnd);
    logic [7:0]  rc = 8'h01;
    logic [31:0] rot, sub, t, n0, n1, n2, n3;
    for (int i = 0; i < int'(rnd); i++) rc = xt(rc);
    rot = {pre[23:0], pre[31:24]};
    sub = {sbox_tab[rot[31:24]], sbox_tab[rot[23:16]], sbox_tab[rot[15:8]], sbox_tab[rot[7:0]]};
    t  = sub ^ {rc, 24'h0};
    n0 = pre[127:96] ^ t;
    n1 = pre[95:64] ^ n0;
    n2 = pre[63:32] ^ n1;
    n3 = pre[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0) begin
        for (int x = 1; x < 256; x++) begin
          if (gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
        end
      end
      sbox_tab[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic calc_sched(input logic [127:0] key);
    exp_rk[0] = key;
    for (int r = 0; r < 10; r++) exp_rk[r+1] = kg_fn(exp_rk[r], 4'(r));
  endtask

  // ---------------- behavioural aes_key_gen models ----------------
  // Results are valid for exactly one cycle; a mistimed capture sees POISON.
  always @(posedge clk) begin
    kg_next_1 <= kg_en_1 ? kg_fn(kg_pre_1, kg_rnd_1) : POISON;
    p0_3      <= kg_en_3 ? kg_fn(kg_pre_3, kg_rnd_3) : POISON;
    p1_3      <= p0_3;
    p2_3      <= p1_3;
  end
  assign kg_next_3 = p2_3;

  // ---------------- stimulus / scoreboard plumbing ----------------
  task automatic rd_issue(input int sel, input logic [3:0] addr, input logic vld,
                          input logic err, input logic [127:0] data);
    sb_ent_t e;
    e = '{vld: vld, err: err, addr: addr, data: data};
    if (sel == 1) begin
      rd_en_1 = 1'b1; rd_addr_1 = addr; sb1.push_back(e);
    end else begin
      rd_en_3 = 1'b1; rd_addr_3 = addr; sb3.push_back(e);
    end
  endtask

  task automatic rd_quiet();
    rd_en_1 = 1'b0;
    rd_en_3 = 1'b0;
  endtask

  // Advance one cycle and score the read port of both instances.
  task automatic step();
    logic s1, s3, r;
    sb_ent_t e;
    s1 = rd_en_1; s3 = rd_en_3; r = rst;
    @(negedge clk);
    n_checks++;
    if (!r && s1) begin
      if (sb1.size() == 0) begin
        n_errors++; $display("FAIL sb1_underflow got=read want=queued_entry");
      end else begin
        e = sb1.pop_front();
        $display("rd dut1 addr=%0d rk=%h vld=%b err=%b", e.addr, rk_1, rk_vld_1, rk_err_1);
        if (rk_vld_1 !== e.vld || rk_err_1 !== e.err || rk_1 !== e.data) begin
          n_errors++;
          $display("FAIL rd1 addr=%0d got vld=%b err=%b rk=%h want vld=%b err=%b rk=%h",
                   e.addr, rk_vld_1, rk_err_1, rk_1, e.vld, e.err, e.data);
        end
      end
    end else if (rk_vld_1 !== 1'b0 || rk_err_1 !== 1'b0) begin
      n_errors++; $display("FAIL idle1 got vld=%b err=%b want 0 0", rk_vld_1, rk_err_1);
    end
    n_checks++;
    if (!r && s3) begin
      if (sb3.size() == 0) begin
        n_errors++; $display("FAIL sb3_underflow got=read want=queued_entry");
      end else begin
        e = sb3.pop_front();
        $display("rd dut3 addr=%0d rk=%h vld=%b err=%b", e.addr, rk_3, rk_vld_3, rk_err_3);
        if (rk_vld_3 !== e.vld || rk_err_3 !== e.err || rk_3 !== e.data) begin
          n_errors++;
          $display("FAIL rd3 addr=%0d got vld=%b err=%b rk=%h want vld=%b err=%b rk=%h",
                   e.addr, rk_vld_3, rk_err_3, rk_3, e.vld, e.err, e.data);
        end
      end
    end else if (rk_vld_3 !== 1'b0 || rk_err_3 !== 1'b0) begin
      n_errors++; $display("FAIL idle3 got vld=%b err=%b want 0 0", rk_vld_3, rk_err_3);
    end
  endtask

  task automatic peek(input int sel, output logic rdy, output logic en, output logic bsy,
                      output logic krdy, output logic [3:0] rn);
    rdy  = (sel == 1) ? ready_1   : ready_3;
    en   = (sel == 1) ? kg_en_1   : kg_en_3;
    bsy  = (sel == 1) ? busy_1    : busy_3;
    krdy = (sel == 1) ? key_rdy_1 : key_rdy_3;
    rn   = (sel == 1) ? kg_rnd_1  : kg_rnd_3;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({key_rdy_1, busy_1, ready_1, kg_en_1, rk_1 == 128'h0, kg_pre_1 == 128'h0} !== 6'b100011) begin
      n_errors++;
      $display("FAIL reset1 got rdy=%b busy=%b ready=%b en=%b rk=%h want 1 0 0 0 rk=0",
               key_rdy_1, busy_1, ready_1, kg_en_1, rk_1);
    end
    n_checks++;
    if ({key_rdy_3, busy_3, ready_3, kg_en_3, rk_3 == 128'h0} !== 5'b10001) begin
      n_errors++;
      $display("FAIL reset3 got rdy=%b busy=%b ready=%b en=%b rk=%h want 1 0 0 0 rk=0",
               key_rdy_3, busy_3, ready_3, kg_en_3, rk_3);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({key_rdy_1, busy_1, ready_1, kg_en_1} !== 4'b1000) begin
      n_errors++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b ready=%b en=%b want 1 0 0 0",
               key_rdy_1, busy_1, ready_1, kg_en_1);
    end
    // Reading before any key is loaded is rejected.
    rd_issue(1, 4'd0, 1'b0, 1'b1, 128'h0);
    step(); rd_quiet();
  endtask

  task automatic expand_and_wait(input int sel, input logic [127:0] key, input int exp_edges,
                                 input bit disturb, input bit rd_old_en,
                                 input logic [127:0] rd_old, input string label);
    logic rdy, en, bsy, krdy;
    logic [3:0] rn;
    int edges = 0;
    int pulses = 0;
    i_key_vld = 1'b1; i_key = key;
    if (rd_old_en) rd_issue(sel, 4'd10, 1'b1, 1'b0, rd_old);
    step(); rd_quiet();
    i_key_vld = 1'b0;
    peek(sel, rdy, en, bsy, krdy, rn);
    while (!rdy && edges < LIMIT) begin
      if (en) begin
        n_checks++;
        if (rn !== 4'(pulses)) begin
          n_errors++; $display("FAIL %s kg_round got=%0d want=%0d", label, rn, pulses);
        end
        pulses++;
      end
      n_checks++;
      if (bsy !== 1'b1 || krdy !== 1'b0) begin
        n_errors++; $display("FAIL %s busy_flags edge=%0d got busy=%b key_rdy=%b want 1 0", label, edges, bsy, krdy);
      end
      if (disturb && edges == 8) begin
        n_checks++;
        if (rn !== 4'd4) begin
          n_errors++; $display("FAIL %s disturb_round got=%0d want=4", label, rn);
        end
        rd_issue(sel, 4'd2, 1'b0, 1'b1, 128'h0);
        i_key_vld = 1'b1; i_key = ~key;
      end
      if (disturb && edges == 12) i_key_vld = 1'b0;
      step(); rd_quiet();
      edges++;
      peek(sel, rdy, en, bsy, krdy, rn);
    end
    i_key_vld = 1'b0;
    $display("%s: keys_ready after %0d edges, %0d kg_en pulses", label, edges, pulses);
    n_checks++;
    if (edges != exp_edges) begin
      n_errors++; $display("FAIL %s ready_latency got=%0d want=%0d", label, edges, exp_edges);
    end
    n_checks++;
    if (pulses != 10) begin
      n_errors++; $display("FAIL %s kg_en_pulses got=%0d want=10", label, pulses);
    end
    n_checks++;
    if ({rdy, bsy, krdy} !== 3'b101) begin
      n_errors++; $display("FAIL %s done_flags got ready=%b busy=%b key_rdy=%b want 1 0 1", label, rdy, bsy, krdy);
    end
  endtask

  task automatic read_all(input int sel);
    for (int a = 0; a < 11; a++) begin
      rd_issue(sel, 4'(a), 1'b1, 1'b0, exp_rk[a]);
      step();
    end
    rd_quiet(); step();
  endtask

  task automatic test_fips_expand();
    calc_sched(FIPS_KEY);
    expand_and_wait(1, FIPS_KEY, 20, 1'b0, 1'b0, 128'h0, "fips_lat1");
    rd_issue(1, 4'd1, 1'b1, 1'b0, FIPS_RK1);   step();
    rd_issue(1, 4'd10, 1'b1, 1'b0, FIPS_RK10); step();
    rd_quiet(); step();
    read_all(1);
  endtask

  task automatic test_bad_reads();
    rd_issue(1, 4'd11, 1'b0, 1'b1, 128'h0);     step();
    rd_issue(1, 4'd15, 1'b0, 1'b1, 128'h0);     step();
    rd_issue(1, 4'd0, 1'b1, 1'b0, FIPS_KEY);    step();
    rd_quiet(); step();
    n_checks++;
    if (rk_1 !== FIPS_KEY) begin
      n_errors++; $display("FAIL rd_hold got=%h want=%h", rk_1, FIPS_KEY);
    end
  endtask

  task automatic test_rekey_with_read();
    calc_sched(SEQ_KEY);
    expand_and_wait(1, SEQ_KEY, 20, 1'b0, 1'b1, FIPS_RK10, "rekey_lat1");
    rd_issue(1, 4'd10, 1'b1, 1'b0, SEQ_RK10); step();
    rd_quiet(); step();
    read_all(1);
  endtask

  task automatic test_busy_disturb();
    calc_sched(FIPS_KEY);
    expand_and_wait(1, FIPS_KEY, 20, 1'b1, 1'b0, 128'h0, "disturb_lat1");
    rd_issue(1, 4'd10, 1'b1, 1'b0, FIPS_RK10); step();
    rd_quiet(); step();
    read_all(1);
  endtask

  task automatic test_rst_mid();
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    i_key_vld = 1'b1; i_key = k;
    step();
    i_key_vld = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (kg_en_1 !== 1'b1 || kg_rnd_1 !== 4'd5) begin
      n_errors++; $display("FAIL rst_mid_round got en=%b rnd=%0d want 1 5", kg_en_1, kg_rnd_1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({key_rdy_1, busy_1, ready_1, kg_en_1} !== 4'b1000) begin
      n_errors++;
      $display("FAIL rst_mid_idle got rdy=%b busy=%b ready=%b en=%b want 1 0 0 0",
               key_rdy_1, busy_1, ready_1, kg_en_1);
    end
    rd_issue(1, 4'd0, 1'b0, 1'b1, 128'h0); step();
    rd_quiet(); step();
    k = {$urandom, $urandom, $urandom, $urandom};
    calc_sched(k);
    expand_and_wait(1, k, 20, 1'b0, 1'b0, 128'h0, "after_rst_lat1");
    read_all(1);
  endtask

  task automatic test_lat3();
    rst = 1'b1; step();
    rst = 1'b0; step();
    calc_sched(FIPS_KEY);
    expand_and_wait(3, FIPS_KEY, 40, 1'b0, 1'b0, 128'h0, "fips_lat3");
    rd_issue(3, 4'd1, 1'b1, 1'b0, FIPS_RK1);   step();
    rd_issue(3, 4'd10, 1'b1, 1'b0, FIPS_RK10); step();
    rd_quiet(); step();
    read_all(3);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_expand();
    test_bad_reads();
    test_rekey_with_read();
    test_busy_disturb();
    test_rst_mid();
    test_lat3();
    rd_quiet(); step(); step();
    n_checks++;
    if (sb1.size() != 0 || sb3.size() != 0) begin
      n_errors++; $display("FAIL sb_drain got=%0d/%0d want=0/0", sb1.size(), sb3.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
